// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: fetch-to-decode instruction queue that holds PC/instruction
// pairs in strict FIFO order. Every entry takes one registered cycle to reach the
// decode side, and there is no same-cycle bypass. flush_i discards all queued
// entries. rst_i is a synchronous, active-low reset that also clears the storage.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  input  logic [XLEN-1:0]        fetch_pc_i,
  input  logic [XLEN-1:0]        fetch_instruction_i,
  output logic                   fetch_ready_o,
  output logic                   decode_valid_o,
  output logic [XLEN-1:0]        decode_pc_o,
  output logic [XLEN-1:0]        decode_instruction_o,
  input  logic                   decode_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  // Handshake qualification. The ready and valid outputs depend only on the
  // registered occupancy (and on rst_i for ready). The other inputs reach them
  // through no combinational path.
  always_comb begin
    not_full       = (count != FULL_COUNT);
    not_empty      = (count != '0);
    fetch_ready_o  = rst_i && not_full;
    decode_valid_o = not_empty;
    push           = fetch_valid_i && fetch_ready_o && !flush_i;
    pop            = decode_valid_o && decode_ready_i && !flush_i && rst_i;
  end

  // Pointer and occupancy tracking. Reset takes priority over flush, and flush
  // takes priority over push and pop. A full queue cannot push while it pops,
  // because fetch_ready_o already reflects the full state.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff reads the pre-edge values regardless of evaluation order.
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. The write pointer selects the slot that a push fills.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is reset explicitly so that no stale entry remains
    // after reset. This is why it is not left as an unreset RAM.
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc_i;
      instr_mem[wr_ptr] <= fetch_instruction_i;
    end
  end

  // Head presentation. The head is gated to zero when the queue is empty. After
  // a flush, stale slot contents therefore never reach decode.
  always_comb begin
    decode_pc_o          = '0;
    decode_instruction_o = '0;
    if (not_empty) begin
      decode_pc_o          = pc_mem[rd_ptr];
      decode_instruction_o = instr_mem[rd_ptr];
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed scenarios plus randomized traffic. The
// behavioural model is a queue of PC/instruction pairs.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             fetch_valid_i;
  logic [XLEN-1:0]  fetch_pc_i;
  logic [XLEN-1:0]  fetch_instruction_i;
  logic             fetch_ready_o;
  logic             decode_valid_o;
  logic [XLEN-1:0]  decode_pc_o;
  logic [XLEN-1:0]  decode_instruction_o;
  logic             decode_ready_i;
  logic [CNT_W-1:0] count_o;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } entry_t;

  entry_t          model_q[$];
  logic [XLEN-1:0] popped[$];
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk_i = ~clk_i;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .fetch_valid_i        (fetch_valid_i),
    .fetch_pc_i           (fetch_pc_i),
    .fetch_instruction_i  (fetch_instruction_i),
    .fetch_ready_o        (fetch_ready_o),
    .decode_valid_o       (decode_valid_o),
    .decode_pc_o          (decode_pc_o),
    .decode_instruction_o (decode_instruction_o),
    .decode_ready_i       (decode_ready_i),
    .count_o              (count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Drive the inputs, compare the outputs against the model at
  // the falling edge, and then advance the model at the rising edge.
  task automatic step(input bit r, input bit f, input bit fv,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                      input bit dr);
    logic [XLEN-1:0] exp_pc;
    logic [XLEN-1:0] exp_ins;
    bit              do_pop;
    bit              do_push;
    rst_i               = r;
    flush_i             = f;
    fetch_valid_i       = fv;
    fetch_pc_i          = pc;
    fetch_instruction_i = ins;
    decode_ready_i      = dr;
    @(negedge clk_i);
    exp_pc  = '0;
    exp_ins = '0;
    if (model_q.size() != 0) begin
      exp_pc  = model_q[0].pc;
      exp_ins = model_q[0].ins;
    end
    check("fetch_ready", 64'(fetch_ready_o), 64'(r && (model_q.size() < DEPTH)));
    check("decode_valid", 64'(decode_valid_o), 64'(model_q.size() != 0));
    check("decode_pc", 64'(decode_pc_o), 64'(exp_pc));
    check("decode_ins", 64'(decode_instruction_o), 64'(exp_ins));
    check("count", 64'(count_o), 64'(model_q.size()));
    if (decode_valid_o && dr && r && !f) popped.push_back(decode_pc_o);
    @(posedge clk_i);
    if (!r || f) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && dr;
      do_push = fv && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: pc, ins: ins});
    end
    #1;
  endtask

  task automatic idle(input bit dr);
    step(1'b1, 1'b0, 1'b0, '0, '0, dr);
  endtask

  initial begin
    int idx;
    bit fv;
    bit acc;
    int n_pop;

    rst_i = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0;
    fetch_pc_i = '0; fetch_instruction_i = '0; decode_ready_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset state, with rst_i held low and a push requested
    step(1'b0, 1'b0, 1'b1, 32'hAAAA, 32'hBBBB, 1'b1);

    // Single entry
    popped.delete();
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0013, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("single_popped_count", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("single_popped_pc", 64'(popped[0]), 64'h100);

    // Fill with backpressure; the fifth push is held off
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0);
    check("fill_count", 64'(count_o), 64'd4);
    check("fill_ready", 64'(fetch_ready_o), 64'd0);
    // Full queue with push and pop together: only the pop happens
    step(1'b1, 1'b0, 1'b1, 32'h1010, 32'h5004, 1'b1);
    check("full_pushpop_count", 64'(count_o), 64'd3);
    check("full_pushpop_ready", 64'(fetch_ready_o), 64'd1);
    step(1'b1, 1'b0, 1'b1, 32'h1010, 32'h5004, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Wrap-around stream with random decode_ready_i
    popped.delete();
    idx = 0;
    for (int c = 0; c < 400 && popped.size() < 10; c++) begin
      fv  = (idx < 10) && ($urandom_range(0, 3) != 0);
      acc = fv && (model_q.size() < DEPTH);
      step(1'b1, 1'b0, fv, 32'(4 * idx), 32'h9000 + 32'(idx), 1'($urandom_range(0, 1)));
      if (acc) idx++;
    end
    check("stream_popped_count", 64'(popped.size()), 64'd10);
    n_pop = (popped.size() < 10) ? popped.size() : 10;
    for (int i = 0; i < n_pop; i++) check("stream_order", 64'(popped[i]), 64'(4 * i));
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Flush together with a push; the pushed entry must never appear
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h700 + 32'(i), 32'h1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(decode_valid_o), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'h300, 32'h33, 1'b0);
    check("post_flush_head", 64'(decode_pc_o), 64'h300);
    idle(1'b1);

    // Reset mid-stream
    step(1'b1, 1'b0, 1'b1, 32'h400, 32'h44, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h404, 32'h45, 1'b0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pc", 64'(decode_pc_o), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'h200, 32'h22, 1'b0);
    check("rst_release_head", 64'(decode_pc_o), 64'h200);
    idle(1'b1);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
